// File: rtl/nn_pkg.sv
// Shared helpers for the neuron datapath: width math and signed saturate/wrap conversion.
package nn_pkg;

    localparam int MAX_W = 128;

    typedef struct packed {
        logic signed [MAX_W-1:0] value;
        logic                    sat;
    } conv_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int acc_width(input int w, input int n);
        return w + clog2(n);
    endfunction

    // Narrow v to a signed field of the given width, clamping or wrapping; sat flags a misfit.
    function automatic conv_t sat_conv(input logic signed [MAX_W-1:0] v,
                                       input int width,
                                       input bit saturate);
        conv_t                   res;
        logic signed [MAX_W-1:0] max_v;
        logic signed [MAX_W-1:0] min_v;
        logic signed [MAX_W-1:0] wrapped;
        logic                    fits;
        max_v   = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
        min_v   = ~max_v;
        wrapped = (v <<< (MAX_W - width)) >>> (MAX_W - width);
        fits    = (wrapped == v);
        res.sat = !fits;
        if (!saturate || fits)
            res.value = wrapped;
        else if (v > max_v)
            res.value = max_v;
        else
            res.value = min_v;
        return res;
    endfunction

endpackage

// File: rtl/weighted_sum_tree_stage.sv
// One registered adder-tree level: sums adjacent term pairs, halving the term count.
module weighted_sum_tree_stage
    import nn_pkg::*;
#(
    parameter int N_TERMS = 2,
    parameter int TERM_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic [N_TERMS*TERM_W-1:0]     in_terms,
    output logic                          out_valid,
    output logic [N_TERMS/2*TERM_W-1:0]   out_terms
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_terms <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            for (int i = 0; i < N_TERMS / 2; i++)
                out_terms[i*TERM_W +: TERM_W] <= in_terms[2*i*TERM_W +: TERM_W]
                                               + in_terms[(2*i+1)*TERM_W +: TERM_W];
        end
    end

endmodule

// File: rtl/weighted_sum_tree.sv
// Pipelined weighted sum of x-gated signed weights via a registered binary adder tree,
// with valid/ready flow control and saturating or wrapping output conversion.
module weighted_sum_tree
    import nn_pkg::*;
#(
    parameter int N        = 8,
    parameter int W        = 32,
    parameter int OUT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       x,
    input  logic [W*N-1:0]     w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   sum,
    output logic               sat
);

    localparam int LEVELS = clog2(N);
    localparam int ACC_W  = acc_width(W, N);
    localparam int P      = 1 << LEVELS;

    logic                     adv;
    logic [P-1:0]             x_pad;
    logic [P*W-1:0]           w_pad;
    logic [P*ACC_W-1:0]       terms;
    logic [P*ACC_W-1:0]       s0_data;
    logic                     s0_valid;
    wire  [(P-1)*ACC_W-1:0]   lvl_data;
    wire  [LEVELS:1]          lvl_valid;
    logic signed [ACC_W-1:0]  final_acc;
    conv_t                    conv;
    wire                      unused_hi;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Unused upper terms stay zero so a non-power-of-two N pads cleanly.
    assign x_pad = P'(x);
    assign w_pad = (P*W)'(w);

    always_comb begin
        terms = '0;
        for (int i = 0; i < P; i++)
            if (x_pad[i])
                terms[i*ACC_W +: ACC_W] = ACC_W'($signed(w_pad[i*W +: W]));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
        end else if (adv) begin
            s0_valid <= in_valid;
            s0_data  <= terms;
        end
    end

    // lvl_data packs every level's outputs back to back; level k starts at term P - (P >> (k-1)).
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int NI  = P >> (k - 1);
        localparam int OFF = P - NI;
        wire [NI*ACC_W-1:0] d_in;
        wire                v_in;
        if (k == 1) begin : g_first
            assign d_in = s0_data;
            assign v_in = s0_valid;
        end else begin : g_next
            assign d_in = lvl_data[(OFF-NI)*ACC_W +: NI*ACC_W];
            assign v_in = lvl_valid[k-1];
        end
        weighted_sum_tree_stage #(
            .N_TERMS (NI),
            .TERM_W  (ACC_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .in_valid  (v_in),
            .in_terms  (d_in),
            .out_valid (lvl_valid[k]),
            .out_terms (lvl_data[OFF*ACC_W +: NI/2*ACC_W])
        );
    end

    assign final_acc = lvl_data[(P-2)*ACC_W +: ACC_W];
    assign out_valid = lvl_valid[LEVELS];

    assign conv      = sat_conv(MAX_W'(final_acc), OUT_W, SATURATE != 0);
    assign sum       = conv.value[OUT_W-1:0];
    assign sat       = conv.sat;
    assign unused_hi = ^conv.value[MAX_W-1:OUT_W];

endmodule

// File: tb/tb_weighted_sum_tree.sv
// Directed bench for weighted_sum_tree: saturating and wrapping N=8 instances plus an N=5 instance.
module tb_weighted_sum_tree;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [7:0]   x;
    logic [255:0] w;
    logic         in_ready, out_valid, sat;
    logic [31:0]  sum;
    logic         b_in_ready, b_out_valid, b_sat;
    logic [31:0]  b_sum;
    logic         c_in_valid, c_out_ready;
    logic [4:0]   c_x;
    logic [79:0]  c_w;
    logic         c_in_ready, c_out_valid, c_sat;
    logic [18:0]  c_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    weighted_sum_tree #(.N(8), .W(32), .OUT_W(32), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .sat(sat));

    weighted_sum_tree #(.N(8), .W(32), .OUT_W(32), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .x(x), .w(w),
        .out_valid(b_out_valid), .out_ready(out_ready), .sum(b_sum), .sat(b_sat));

    weighted_sum_tree #(.N(5), .W(16), .OUT_W(19), .SATURATE(1)) u_n5 (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .x(c_x), .w(c_w),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .sum(c_sum), .sat(c_sat));

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Present one input, return edges from acceptance until out_valid; leaves bench at a negedge.
    task automatic apply_one(input logic [7:0] xv, input logic [255:0] wv, output int lat);
        @(negedge clk);
        x = xv; w = wv; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic apply_c(input logic [4:0] xv, input logic [79:0] wv, output int lat);
        @(negedge clk);
        c_x = xv; c_w = wv; c_in_valid = 1'b1;
        @(negedge clk);
        c_in_valid = 1'b0;
        lat = 1;
        while (!c_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic stream(input int n, input logic [7:0] xs[8], input logic [31:0] wv,
                          input int st_lo, input int st_hi, input bit chk_consec,
                          input logic [31:0] exps[8]);
        logic [31:0] exp_q[$];
        logic [31:0] held, e;
        int sent, got, last, extra;
        sent = 0; got = 0; last = 0; extra = 0; held = '0;
        for (int c = 1; c <= 60 && got < n; c++) begin
            @(negedge clk);
            out_ready = !(c >= st_lo && c <= st_hi);
            if (sent < n) begin
                in_valid = 1'b1; x = xs[sent]; w = {8{wv}};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                if (c > st_lo) check("stall_hold", sum, held);
            end
            held = sum;
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                check("stream_order", sum, e);
                if (chk_consec && got > 0) check("stream_consec", c - last, 1);
                last = c;
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(exps[sent]);
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_count", got, n);
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("stream_no_dup", extra, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, seen;
        logic [7:0]  xs[8];
        logic [31:0] es[8];

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; w = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_x = '0; c_w = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_sat", sat, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_wrap_valid", b_out_valid, 0);
        check("rst_n5_valid", c_out_valid, 0);
        rst = 1'b1;

        apply_one(8'hFF, {8{32'd1}}, lat);
        check("ones_lat", lat, 4);
        check("ones_sum", sum, 8);
        check("ones_sat", sat, 0);
        check("ones_wrap_sum", b_sum, 8);

        apply_one(8'h81, {32'hFFFFFFFD, {6{32'd100}}, 32'd5}, lat);
        check("mixed_sum", sum, 2);
        check("mixed_sat", sat, 0);

        apply_one(8'hFF, {8{32'h7FFFFFFF}}, lat);
        check("pos_sat_sum", sum, 64'h7FFFFFFF);
        check("pos_sat_flag", sat, 1);
        check("pos_wrap_sum", b_sum, 64'hFFFFFFF8);
        check("pos_wrap_flag", b_sat, 1);

        apply_one(8'hFF, {8{32'h80000000}}, lat);
        check("neg_sat_sum", sum, 64'h80000000);
        check("neg_sat_flag", sat, 1);
        check("neg_wrap_sum", b_sum, 0);
        check("neg_wrap_flag", b_sat, 1);

        apply_one(8'h03, {8{32'h40000000}}, lat);
        check("just_over_sum", sum, 64'h7FFFFFFF);
        check("just_over_sat", sat, 1);
        check("just_over_wrap", b_sum, 64'h80000000);
        check("just_over_wflag", b_sat, 1);

        apply_one(8'h01, {8{32'h7FFFFFFF}}, lat);
        check("max_fit_sum", sum, 64'h7FFFFFFF);
        check("max_fit_sat", sat, 0);
        check("max_fit_wflag", b_sat, 0);

        apply_one(8'h80, {8{32'h80000000}}, lat);
        check("min_fit_sum", sum, 64'h80000000);
        check("min_fit_sat", sat, 0);

        apply_one(8'h00, {8{32'h12345678}}, lat);
        check("zero_x_sum", sum, 0);
        check("zero_x_sat", sat, 0);

        xs = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};
        es = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd0, 32'd0, 32'd0, 32'd0};
        stream(4, xs, 32'd10, 100, 0, 1'b1, es);

        xs = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h00, 8'h00};
        es = '{32'd7, 32'd14, 32'd21, 32'd28, 32'd35, 32'd42, 32'd0, 32'd0};
        stream(6, xs, 32'd7, 5, 8, 1'b0, es);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x = 8'hFF; w = {8{32'd1}}; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_flushed", seen, 0);
        apply_one(8'h0F, {8{32'd3}}, lat);
        check("postrst_lat", lat, 4);
        check("postrst_sum", sum, 12);

        apply_c(5'b11111, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, lat);
        check("n5_lat", lat, 4);
        check("n5_sum", $signed(c_sum), 15);
        check("n5_sat", c_sat, 0);
        apply_c(5'b10000, {16'hFFF9, 16'd9, 16'd9, 16'd9, 16'd9}, lat);
        check("n5_neg_sum", $signed(c_sum), -7);
        check("n5_neg_sat", c_sat, 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
